// File: rtl/match_referee.sv
// Match-level referee: counts legal balls per innings and sequences
// INN1 -> BREAK -> INN2 -> DONE, publishing registered result and chase figures.
module match_referee #(
    parameter int BALLS_MAX = 120,
    parameter int WKT_MAX   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        delivery,
    input  logic        team_sel,
    input  logic [11:0] team1_data,
    input  logic [11:0] team2_data,
    output logic [6:0]  balls1,
    output logic [6:0]  balls2,
    output logic [8:0]  target,
    output logic [8:0]  runs_needed,
    output logic [6:0]  balls_left,
    output logic        inning_over,
    output logic        game_over,
    output logic        winner,
    output logic        tie,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_INN1  = 2'b00,
        S_BREAK = 2'b01,
        S_INN2  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [6:0] BALLS_LIM = 7'(BALLS_MAX);
    localparam logic [3:0] WKT_LIM   = 4'(WKT_MAX);

    state_t      state_q, state_d;
    logic [6:0]  balls1_q, balls1_d;
    logic [6:0]  balls2_q, balls2_d;
    logic [8:0]  target_q, target_d;
    logic [8:0]  runs_needed_q, runs_needed_d;
    logic [6:0]  balls_left_q, balls_left_d;
    logic        inning_over_q, inning_over_d;
    logic        game_over_q, game_over_d;
    logic        winner_q, winner_d;
    logic        tie_q, tie_d;

    logic [7:0]  runs1, runs2;
    logic [3:0]  wkts1, wkts2;
    logic        inn1_end, inn2_end;

    assign runs1 = team1_data[11:4];
    assign wkts1 = team1_data[3:0];
    assign runs2 = team2_data[11:4];
    assign wkts2 = team2_data[3:0];

    // End conditions look at registered ball counts, so an innings closes one
    // edge after its final delivery, once the scorer totals have settled.
    assign inn1_end = (balls1_q == BALLS_LIM) || (wkts1 >= WKT_LIM);
    assign inn2_end = ({1'b0, runs2} >= target_q) || (wkts2 >= WKT_LIM) ||
                      (balls2_q == BALLS_LIM);

    // State register; reset aborts the match immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_INN1;
        else       state_q <= state_d;
    end

    // Next-state logic for the innings sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INN1:  if (inn1_end) state_d = S_BREAK;
            S_BREAK: if (team_sel) state_d = S_INN2;
            S_INN2:  if (inn2_end) state_d = S_DONE;
            default: state_d = S_DONE;
        endcase
    end

    // Next values of every published figure, derived from the upcoming state.
    always_comb begin
        balls1_d = balls1_q;
        balls2_d = balls2_q;
        target_d = target_q;
        winner_d = winner_q;
        tie_d    = tie_q;
        // Only deliveries from the side currently batting are legal balls.
        if ((state_q == S_INN1) && delivery && !team_sel && (balls1_q < BALLS_LIM))
            balls1_d = balls1_q + 7'd1;
        if ((state_q == S_INN2) && delivery && team_sel && (balls2_q < BALLS_LIM))
            balls2_d = balls2_q + 7'd1;
        // Nine-bit target so a 255-run innings sets 256 without wrapping.
        if ((state_q == S_INN1) && (state_d == S_BREAK))
            target_d = {1'b0, runs1} + 9'd1;
        // Result is frozen on entry to DONE and decided on runs alone.
        if ((state_q == S_INN2) && (state_d == S_DONE)) begin
            winner_d = (runs2 > runs1);
            tie_d    = (runs2 == runs1);
        end
        inning_over_d = (state_d == S_BREAK);
        game_over_d   = (state_d == S_DONE);
        runs_needed_d = 9'd0;
        if (state_d[1] && (target_d > {1'b0, runs2}))
            runs_needed_d = target_d - {1'b0, runs2};
        balls_left_d = state_d[1] ? (BALLS_LIM - balls2_d) : (BALLS_LIM - balls1_d);
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            balls1_q      <= 7'd0;
            balls2_q      <= 7'd0;
            target_q      <= 9'd0;
            runs_needed_q <= 9'd0;
            balls_left_q  <= BALLS_LIM;
            inning_over_q <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
            tie_q         <= 1'b0;
        end else begin
            balls1_q      <= balls1_d;
            balls2_q      <= balls2_d;
            target_q      <= target_d;
            runs_needed_q <= runs_needed_d;
            balls_left_q  <= balls_left_d;
            inning_over_q <= inning_over_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            tie_q         <= tie_d;
        end
    end

    assign balls1      = balls1_q;
    assign balls2      = balls2_q;
    assign target      = target_q;
    assign runs_needed = runs_needed_q;
    assign balls_left  = balls_left_q;
    assign inning_over = inning_over_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign tie         = tie_q;
    assign state       = state_q;

endmodule

// File: tb/tb_match_referee.sv
// Self-checking bench for match_referee: scripted match scenarios plus
// randomized matches compared against a ball-by-ball match model.
module tb_match_referee;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        delivery = 1'b0;
    logic        team_sel = 1'b0;
    logic [11:0] team1_data = 12'd0;
    logic [11:0] team2_data = 12'd0;
    logic [6:0]  balls1, balls2, balls_left;
    logic [8:0]  target, runs_needed;
    logic        inning_over, game_over, winner, tie;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    // Match model: scores, wickets, legal balls and phase (0 INN1 .. 3 DONE).
    int  m_r1, m_w1, m_r2, m_w2, m_b1, m_b2, m_phase, m_target;
    bit  m_winner, m_tie;
    bit  bat_side;

    match_referee dut (
        .clk(clk), .reset(reset), .delivery(delivery), .team_sel(team_sel),
        .team1_data(team1_data), .team2_data(team2_data),
        .balls1(balls1), .balls2(balls2), .target(target), .runs_needed(runs_needed),
        .balls_left(balls_left), .inning_over(inning_over), .game_over(game_over),
        .winner(winner), .tie(tie), .state(state)
    );

    always #5 clk = ~clk;

    function automatic int exp_needed();
        if (m_phase >= 2 && m_target > m_r2) return m_target - m_r2;
        return 0;
    endfunction

    function automatic int exp_left();
        return (m_phase >= 2) ? 120 - m_b2 : 120 - m_b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; delivery = 1'b0; team_sel = 1'b0;
        team1_data = 12'd0; team2_data = 12'd0;
        m_r1 = 0; m_w1 = 0; m_r2 = 0; m_w2 = 0; m_b1 = 0; m_b2 = 0;
        m_phase = 0; m_target = 0; m_winner = 0; m_tie = 0; bat_side = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One delivery edge by 'team', scorer updates totals after it, then one idle edge.
    task automatic ball(input bit team, input int add_r, input int add_w);
        @(negedge clk);
        delivery = 1'b1; team_sel = team;
        @(posedge clk);
        if (m_phase == 0 && team == 0 && m_b1 < 120) m_b1++;
        else if (m_phase == 2 && team == 1 && m_b2 < 120) m_b2++;
        #1;
        delivery = 1'b0; team_sel = bat_side;
        if (team == 0) begin m_r1 += add_r; m_w1 += add_w; end
        else begin m_r2 += add_r; m_w2 += add_w; end
        team1_data = {8'(m_r1), 4'(m_w1)};
        team2_data = {8'(m_r2), 4'(m_w2)};
        @(posedge clk);
        if (m_phase == 0 && (m_b1 == 120 || m_w1 >= 10)) begin
            m_phase = 1; m_target = m_r1 + 1;
        end else if (m_phase == 2 && (m_r2 >= m_target || m_w2 >= 10 || m_b2 == 120)) begin
            m_phase = 3; m_winner = (m_r2 > m_r1); m_tie = (m_r2 == m_r1);
        end
        #1;
    endtask

    task automatic start_inn2();
        @(negedge clk);
        bat_side = 1'b1; team_sel = 1'b1;
        @(posedge clk);
        if (m_phase == 1) m_phase = 2;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({state, inning_over, game_over, winner, tie} !== 6'b0 || balls1 !== 7'd0 ||
            balls2 !== 7'd0 || target !== 9'd0 || runs_needed !== 9'd0 || balls_left !== 7'd120) begin
            n_fail++;
            $display("FAIL reset_values: state=%0d io=%0d go=%0d w=%0d t=%0d b1=%0d b2=%0d tgt=%0d rn=%0d bl=%0d required all 0, bl=120",
                     state, inning_over, game_over, winner, tie, balls1, balls2, target, runs_needed, balls_left);
        end
        $display("reset: state=%0d balls_left=%0d", state, balls_left);
    endtask

    task automatic test_first_innings();
        do_reset();
        for (int i = 1; i <= 119; i++) begin
            ball(0, (i <= 50) ? 1 : 0, 0);
            if (i % 40 == 0) begin
                ball(1, 0, 0);
                n_checks++;
                if (balls1 !== 7'(m_b1) || state !== 2'd0) begin
                    n_fail++;
                    $display("FAIL stray_inn1: balls1=%0d state=%0d required balls1=%0d state=0", balls1, state, m_b1);
                end
            end
        end
        // Final legal ball: counted on its edge, BREAK follows one edge later.
        @(negedge clk);
        delivery = 1'b1; team_sel = 1'b0;
        @(posedge clk); #1;
        delivery = 1'b0;
        n_checks++;
        if (balls1 !== 7'd120 || state !== 2'd0 || inning_over !== 1'b0) begin
            n_fail++;
            $display("FAIL last_ball_edge: balls1=%0d state=%0d io=%0d required 120/0/0", balls1, state, inning_over);
        end
        @(posedge clk); #1;
        m_b1 = 120; m_phase = 1; m_target = 51;
        n_checks++;
        if (state !== 2'd1 || inning_over !== 1'b1 || target !== 9'd51 || balls_left !== 7'd0) begin
            n_fail++;
            $display("FAIL inn1_break: state=%0d io=%0d target=%0d bl=%0d required 1/1/51/0", state, inning_over, target, balls_left);
        end
        $display("innings1 full: balls1=%0d target=%0d", balls1, target);
        repeat (3) ball(0, 0, 0);
        n_checks++;
        if (balls1 !== 7'd120 || state !== 2'd1 || runs_needed !== 9'd0) begin
            n_fail++;
            $display("FAIL break_ignores: balls1=%0d state=%0d rn=%0d required 120/1/0", balls1, state, runs_needed);
        end
    endtask

    task automatic test_chase();
        start_inn2();
        n_checks++;
        if (state !== 2'd2 || inning_over !== 1'b0 || runs_needed !== 9'd51 || balls_left !== 7'd120) begin
            n_fail++;
            $display("FAIL inn2_entry: state=%0d io=%0d rn=%0d bl=%0d required 2/0/51/120", state, inning_over, runs_needed, balls_left);
        end
        for (int i = 1; i <= 30; i++) begin
            ball(1, (i <= 25 || i == 30) ? 2 : 0, 0);
            if (i < 30) begin
                n_checks++;
                if (state !== 2'd2 || runs_needed !== 9'(exp_needed()) || balls2 !== 7'(i)) begin
                    n_fail++;
                    $display("FAIL chase_ball: ball=%0d state=%0d rn=%0d b2=%0d required 2/%0d/%0d", i, state, runs_needed, balls2, exp_needed(), i);
                end
            end
        end
        n_checks++;
        if (state !== 2'd3 || game_over !== 1'b1 || winner !== 1'b1 || tie !== 1'b0 ||
            balls2 !== 7'd30 || runs_needed !== 9'd0 || balls_left !== 7'd90) begin
            n_fail++;
            $display("FAIL chase_done: state=%0d go=%0d w=%0d t=%0d b2=%0d rn=%0d bl=%0d required 3/1/1/0/30/0/90",
                     state, game_over, winner, tie, balls2, runs_needed, balls_left);
        end
        $display("chase: runs2=%0d balls2=%0d winner=%0d", m_r2, balls2, winner);
        ball(1, 0, 0);
        n_checks++;
        if (balls2 !== 7'd30 || state !== 2'd3) begin
            n_fail++;
            $display("FAIL done_holds: balls2=%0d state=%0d required 30/3", balls2, state);
        end
    endtask

    task automatic test_defend();
        do_reset();
        for (int i = 1; i <= 37; i++)
            ball(0, (i == 37) ? 8 : 2, (i % 4 == 0 || i == 37) ? 1 : 0);
        n_checks++;
        if (state !== 2'd1 || balls1 !== 7'd37 || target !== 9'd81) begin
            n_fail++;
            $display("FAIL allout_inn1: state=%0d b1=%0d target=%0d required 1/37/81", state, balls1, target);
        end
        repeat (2) ball(0, 0, 0);
        n_checks++;
        if (balls1 !== 7'd37 || balls_left !== 7'd83) begin
            n_fail++;
            $display("FAIL allout_hold: b1=%0d bl=%0d required 37/83", balls1, balls_left);
        end
        start_inn2();
        for (int i = 1; i <= 40; i++)
            ball(1, (i <= 20) ? 1 : 2, (i % 4 == 0) ? 1 : 0);
        n_checks++;
        if (state !== 2'd3 || winner !== 1'b0 || tie !== 1'b0 || balls2 !== 7'd40 ||
            runs_needed !== 9'd21 || balls_left !== 7'd80) begin
            n_fail++;
            $display("FAIL defend_done: state=%0d w=%0d t=%0d b2=%0d rn=%0d bl=%0d required 3/0/0/40/21/80",
                     state, winner, tie, balls2, runs_needed, balls_left);
        end
        $display("defend: runs1=%0d runs2=%0d winner=%0d", m_r1, m_r2, winner);
    endtask

    task automatic test_tie();
        do_reset();
        for (int i = 1; i <= 120; i++) ball(0, (i <= 70) ? 1 : 0, 0);
        start_inn2();
        for (int i = 1; i <= 120; i++) ball(1, (i <= 70) ? 1 : 0, 0);
        n_checks++;
        if (state !== 2'd3 || game_over !== 1'b1 || tie !== 1'b1 || winner !== 1'b0 ||
            balls2 !== 7'd120 || balls_left !== 7'd0 || runs_needed !== 9'd1) begin
            n_fail++;
            $display("FAIL tie_done: state=%0d go=%0d t=%0d w=%0d b2=%0d bl=%0d rn=%0d required 3/1/1/0/120/0/1",
                     state, game_over, tie, winner, balls2, balls_left, runs_needed);
        end
        $display("tie: runs1=%0d runs2=%0d tie=%0d", m_r1, m_r2, tie);
    endtask

    task automatic test_random_matches();
        for (int mt = 0; mt < 4; mt++) begin
            do_reset();
            for (int k = 0; k < 2; k++) begin
                int guard = 0;
                int goal  = (k == 0) ? 1 : 3;
                if (k == 1) begin
                    repeat ($urandom_range(0, 3)) ball(0, 0, 0);
                    start_inn2();
                end
                while (m_phase != goal && guard < 400) begin
                    bit team, stray;
                    int add_r, add_w;
                    guard++;
                    team  = bat_side;
                    stray = ($urandom_range(0, 7) == 0);
                    add_r = $urandom_range(0, 6);
                    add_w = ($urandom_range(0, 11) == 0) ? 1 : 0;
                    if (stray) begin team = (k == 0); add_r = 0; add_w = 0; end
                    if (((team == 0) ? m_r1 : m_r2) + add_r > 255) add_r = 0;
                    ball(team, add_r, add_w);
                    n_checks++;
                    if (balls1 !== 7'(m_b1) || balls2 !== 7'(m_b2) || state !== 2'(m_phase) ||
                        balls_left !== 7'(exp_left()) || runs_needed !== 9'(exp_needed())) begin
                        n_fail++;
                        $display("FAIL rand_ball: match=%0d b1=%0d b2=%0d st=%0d bl=%0d rn=%0d required %0d/%0d/%0d/%0d/%0d",
                                 mt, balls1, balls2, state, balls_left, runs_needed,
                                 m_b1, m_b2, m_phase, exp_left(), exp_needed());
                    end
                end
                n_checks++;
                if (m_phase != goal) begin
                    n_fail++;
                    $display("FAIL rand_timeout: match=%0d innings=%0d phase=%0d required %0d", mt, k + 1, m_phase, goal);
                end
            end
            n_checks++;
            if (target !== 9'(m_target) || game_over !== 1'b1 || winner !== m_winner || tie !== m_tie) begin
                n_fail++;
                $display("FAIL rand_result: match=%0d tgt=%0d go=%0d w=%0d t=%0d required %0d/1/%0d/%0d",
                         mt, target, game_over, winner, tie, m_target, m_winner, m_tie);
            end
            $display("random match %0d: r1=%0d/%0d b1=%0d r2=%0d/%0d b2=%0d winner=%0d tie=%0d",
                     mt, m_r1, m_w1, m_b1, m_r2, m_w2, m_b2, winner, tie);
        end
    endtask

    task automatic test_reset_mid_inn2();
        do_reset();
        for (int i = 1; i <= 10; i++) ball(0, 3, 1);
        start_inn2();
        repeat (5) ball(1, 1, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({state, inning_over, game_over, winner, tie} !== 6'b0 || balls1 !== 7'd0 ||
            balls2 !== 7'd0 || target !== 9'd0 || runs_needed !== 9'd0 || balls_left !== 7'd120) begin
            n_fail++;
            $display("FAIL reset_mid_inn2: state=%0d b1=%0d b2=%0d tgt=%0d rn=%0d bl=%0d required 0/0/0/0/0/120",
                     state, balls1, balls2, target, runs_needed, balls_left);
        end
        $display("reset mid innings2: state=%0d balls2=%0d", state, balls2);
        do_reset();
    endtask

    task automatic test_target_256();
        do_reset();
        for (int i = 1; i <= 10; i++) ball(0, (i == 10) ? 30 : 25, 1);
        n_checks++;
        if (state !== 2'd1 || target !== 9'd256 || balls1 !== 7'd10) begin
            n_fail++;
            $display("FAIL target_256: state=%0d target=%0d b1=%0d required 1/256/10", state, target, balls1);
        end
        start_inn2();
        n_checks++;
        if (runs_needed !== 9'd256) begin
            n_fail++;
            $display("FAIL needed_256: rn=%0d required 256", runs_needed);
        end
        $display("max innings: runs1=%0d target=%0d", m_r1, target);
    endtask

    initial begin
        test_reset();
        test_first_innings();
        test_chase();
        test_defend();
        test_tie();
        test_random_matches();
        test_reset_mid_inn2();
        test_target_256();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
